regfile_write_bank: RTL and testbench
=====================================

// Module: regfile_write_bank
// PURPOSE
//   Write side of the CPU register file: 32 x 32-bit storage, a 5-to-32 write-address
//   decoder and byte-strobed write logic. Parallel outputs r0..r31 feed the register-file
//   read muxes (32-to-1, select = rs/rt field). A write from the writeback stage commits
//   on the rising clock edge and is visible on rN in the next cycle.
// PARAMETERS
//   N          32  data width per register, bits (multiple of 8)
//   ZERO_REG    1  1: r0 is hardwired to 0 and writes to it are dropped; 0: r0 is writable
// PORTS
//   clk      in   1      single clock, rising edge
//   reset_n  in   1      asynchronous, active-low reset
//   we       in   1      write request, sampled on rising clk
//   waddr    in   5      destination register index
//   wdata    in   N      write data
//   wstrb    in   N/8    byte enables; bit k selects wdata[8k+7:8k]
//   r0..r31  out  N each current register contents (registered outputs)
//   wr_ack   out  1      one-cycle pulse: a write committed on the previous edge
//   wr_addr  out  5      index of the last committed write; held until the next commit
// BEHAVIOUR
//   - Reset: reset_n=0 asynchronously forces r0..r31=0, wr_ack=0, wr_addr=0, whatever
//     the state of clk. Release is synchronous to the next rising edge. A write in flight
//     on the edge where reset asserts is lost.
//   - Write: on a rising edge with we=1, register[waddr] byte k <= wdata byte k for each
//     wstrb[k]=1. Bytes with wstrb[k]=0 keep their old value. Other registers are unchanged.
//   - Latency: one cycle. New data appears on rN and wr_ack=1 in the cycle after the edge.
//   - wr_ack: set to 1 on an edge where a write commits. Cleared on every other edge.
//     No stall or back-pressure exists: a write is accepted on every cycle.
//   - Dropped writes: we=1 with wstrb=0, or ZERO_REG=1 with waddr=0. No register changes,
//     wr_ack stays 0 and wr_addr holds its previous value.
//   - Back-to-back writes to the same index: the later write overwrites byte-by-byte.
//     Strobed-off bytes keep the value left by the earlier write.
//   - There is no read-during-write bypass. In the cycle of the edge, rN shows the old
//     value. Any forwarding belongs in the pipeline forwarding unit, not in this block.
//   - waddr and wdata are don't-care when we=0. X on we must not corrupt storage:
//     the implementation qualifies writes with (we === 1'b1) in simulation only.
//   - Decoder: exactly one-hot when we=1, all-zero when we=0. Bit 0 is forced to 0
//     when ZERO_REG=1.
// STRUCTURE
//   - Shared include regfile_defs.vh holds REG_COUNT=32, REG_ADDR_W=5, DATA_W=32 and
//     REG_ZERO=5'd0. The read muxes use the same include.
//   - Sub-module decoder_5to32 (en, a[4:0] -> y[31:0] one-hot): the inverse of the
//     read mux. Instantiated once here.
//   - Storage: 32 always blocks, or a generate loop, each with async-reset flops and
//     per-byte enables = y[i] & wstrb[k].
// TESTING
//   1. Reset mid-run: write 0xDEADBEEF to r5, then pulse reset_n low between clock edges
//      -> r5=0 immediately, wr_ack=0, wr_addr=0.
//   2. Full write: we=1, waddr=7, wdata=0x12345678, wstrb=4'hF -> next cycle
//      r7=0x12345678, wr_ack=1, wr_addr=7; all other rN unchanged.
//   3. Byte strobe: r7=0x12345678, then write 0xAABBCCDD with wstrb=4'b0101
//      -> r7=0x12BB56DD.
//   4. Zero register: ZERO_REG=1, write 0xFFFFFFFF to waddr=0 -> r0=0, wr_ack=0,
//      wr_addr unchanged. With ZERO_REG=0 -> r0=0xFFFFFFFF.
//   5. Back-to-back: write r31=0x1 then r31=0x2 on consecutive cycles -> wr_ack high
//      for 2 cycles, r31=0x2. Sweep all 32 indices with value idx*0x01010101 and read
//      each back through the 32-to-1 read mux.
//   6. Idle and X: we=0 with random waddr/wdata for 100 cycles -> no rN changes;
//      we=X -> no rN changes.

Source files
------------

// File: rtl/regfile_write_bank_pkg.sv
// Shared register-file geometry for the write bank, its decoder and
// the read muxes.
package regfile_write_bank_pkg;
   localparam int REG_COUNT = 32;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/decoder_5to32.sv
// Write-address decoder: one-hot select of the destination register,
// all-zero while disabled.
module decoder_5to32
   import regfile_write_bank_pkg::*;
(
   input  logic                  en,
   input  logic [REG_ADDR_W-1:0] a,
   output logic [REG_COUNT-1:0]  y
);

   always_comb begin
      y = '0;
      if (en) y[a] = 1'b1;
   end

endmodule

// File: rtl/regfile_write_bank.sv
// Register-file write side: 32 x N storage with byte-strobed writes,
// commit acknowledge and last-written index.
module regfile_write_bank
   import regfile_write_bank_pkg::*;
#(
   parameter int N        = DATA_W,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] waddr,
   input  logic [N-1:0]          wdata,
   input  logic [N/8-1:0]        wstrb,
   output logic [N-1:0]          r0,
   output logic [N-1:0]          r1,
   output logic [N-1:0]          r2,
   output logic [N-1:0]          r3,
   output logic [N-1:0]          r4,
   output logic [N-1:0]          r5,
   output logic [N-1:0]          r6,
   output logic [N-1:0]          r7,
   output logic [N-1:0]          r8,
   output logic [N-1:0]          r9,
   output logic [N-1:0]          r10,
   output logic [N-1:0]          r11,
   output logic [N-1:0]          r12,
   output logic [N-1:0]          r13,
   output logic [N-1:0]          r14,
   output logic [N-1:0]          r15,
   output logic [N-1:0]          r16,
   output logic [N-1:0]          r17,
   output logic [N-1:0]          r18,
   output logic [N-1:0]          r19,
   output logic [N-1:0]          r20,
   output logic [N-1:0]          r21,
   output logic [N-1:0]          r22,
   output logic [N-1:0]          r23,
   output logic [N-1:0]          r24,
   output logic [N-1:0]          r25,
   output logic [N-1:0]          r26,
   output logic [N-1:0]          r27,
   output logic [N-1:0]          r28,
   output logic [N-1:0]          r29,
   output logic [N-1:0]          r30,
   output logic [N-1:0]          r31,
   output logic                  wr_ack,
   output logic [REG_ADDR_W-1:0] wr_addr
);

   localparam int NB = N / 8;
   localparam logic [REG_COUNT-1:0] ZMASK =
      (ZERO_REG != 0) ? REG_COUNT'(1) : '0;

   logic                  w_we;
   logic                  w_zero_hit;
   logic                  w_commit;
   logic [REG_COUNT-1:0]  w_y;
   logic [REG_COUNT-1:0]  w_dec;
   logic [N-1:0]          r_regs [REG_COUNT];
   logic                  r_ack;
   logic [REG_ADDR_W-1:0] r_addr;

   // An unknown write-enable must never be treated as a write.
`ifdef SYNTHESIS
   assign w_we = we;
`else
   assign w_we = (we === 1'b1);
`endif

   assign w_zero_hit = (ZERO_REG != 0) && (waddr == REG_ZERO);
   assign w_commit   = w_we && (|wstrb) && !w_zero_hit;

   decoder_5to32 u_dec (
      .en (w_we),
      .a  (waddr),
      .y  (w_y)
   );

   assign w_dec = w_y & ~ZMASK;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < REG_COUNT; i++)
            for (int k = 0; k < NB; k++)
               if (w_dec[i] && wstrb[k])
                  r_regs[i][8*k +: 8] <= wdata[8*k +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ack  <= 1'b0;
         r_addr <= '0;
      end else begin
         r_ack <= w_commit;
         if (w_commit) r_addr <= waddr;
      end
   end

   assign wr_ack  = r_ack;
   assign wr_addr = r_addr;

   assign r0  = r_regs[0];
   assign r1  = r_regs[1];
   assign r2  = r_regs[2];
   assign r3  = r_regs[3];
   assign r4  = r_regs[4];
   assign r5  = r_regs[5];
   assign r6  = r_regs[6];
   assign r7  = r_regs[7];
   assign r8  = r_regs[8];
   assign r9  = r_regs[9];
   assign r10 = r_regs[10];
   assign r11 = r_regs[11];
   assign r12 = r_regs[12];
   assign r13 = r_regs[13];
   assign r14 = r_regs[14];
   assign r15 = r_regs[15];
   assign r16 = r_regs[16];
   assign r17 = r_regs[17];
   assign r18 = r_regs[18];
   assign r19 = r_regs[19];
   assign r20 = r_regs[20];
   assign r21 = r_regs[21];
   assign r22 = r_regs[22];
   assign r23 = r_regs[23];
   assign r24 = r_regs[24];
   assign r25 = r_regs[25];
   assign r26 = r_regs[26];
   assign r27 = r_regs[27];
   assign r28 = r_regs[28];
   assign r29 = r_regs[29];
   assign r30 = r_regs[30];
   assign r31 = r_regs[31];

endmodule

// File: tb/tb_regfile_write_bank.sv
// Directed checks of the register-file write bank, with r0 hardwired
// (dut) and with r0 writable (dut_z0).
module tb_regfile_write_bank;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic [31:0] q1 [32];
   logic [31:0] q0 [32];
   logic        ack1, ack0;
   logic [4:0]  addr1, addr0;

   int checks = 0;
   int errors = 0;

   logic [31:0] m [32];
   logic [31:0] snap [32];

   always #5 clk = ~clk;

   regfile_write_bank #(.N(32), .ZERO_REG(1)) dut (
      .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
      .wdata(wdata), .wstrb(wstrb),
      .r0(q1[0]), .r1(q1[1]), .r2(q1[2]), .r3(q1[3]),
      .r4(q1[4]), .r5(q1[5]), .r6(q1[6]), .r7(q1[7]),
      .r8(q1[8]), .r9(q1[9]), .r10(q1[10]), .r11(q1[11]),
      .r12(q1[12]), .r13(q1[13]), .r14(q1[14]), .r15(q1[15]),
      .r16(q1[16]), .r17(q1[17]), .r18(q1[18]), .r19(q1[19]),
      .r20(q1[20]), .r21(q1[21]), .r22(q1[22]), .r23(q1[23]),
      .r24(q1[24]), .r25(q1[25]), .r26(q1[26]), .r27(q1[27]),
      .r28(q1[28]), .r29(q1[29]), .r30(q1[30]), .r31(q1[31]),
      .wr_ack(ack1), .wr_addr(addr1)
   );

   regfile_write_bank #(.N(32), .ZERO_REG(0)) dut_z0 (
      .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr),
      .wdata(wdata), .wstrb(wstrb),
      .r0(q0[0]), .r1(q0[1]), .r2(q0[2]), .r3(q0[3]),
      .r4(q0[4]), .r5(q0[5]), .r6(q0[6]), .r7(q0[7]),
      .r8(q0[8]), .r9(q0[9]), .r10(q0[10]), .r11(q0[11]),
      .r12(q0[12]), .r13(q0[13]), .r14(q0[14]), .r15(q0[15]),
      .r16(q0[16]), .r17(q0[17]), .r18(q0[18]), .r19(q0[19]),
      .r20(q0[20]), .r21(q0[21]), .r22(q0[22]), .r23(q0[23]),
      .r24(q0[24]), .r25(q0[25]), .r26(q0[26]), .r27(q0[27]),
      .r28(q0[28]), .r29(q0[29]), .r30(q0[30]), .r31(q0[31]),
      .wr_ack(ack0), .wr_addr(addr0)
   );

   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        ack;
      logic [4:0]  eaddr;
      int          idx;
      logic [31:0] ev;
   } vec_t;

   vec_t tv [10];

   function automatic logic [31:0] rd(input logic [4:0] idx);
      return q1[idx];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm);
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++)
         if (q1[i] !== m[i]) bad++;
      chk(nm, 32'(bad), 32'd0);
   endtask

   // Hardwired-r0 model: strobed bytes of a live, non-zero index.
   task automatic model_wr(input logic w, input logic [4:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      if (w && a != 5'd0)
         for (int k = 0; k < 4; k++)
            if (s[k]) m[a][8*k +: 8] = d[8*k +: 8];
   endtask

   task automatic drive(input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      we = w; waddr = a; wdata = d; wstrb = s;
      @(posedge clk);
      #1;
      model_wr(w, a, d, s);
      we = 1'b0;
   endtask

   initial begin
      tv[0] = '{1'b1, 5'd7,  32'h12345678, 4'hF, 1'b1, 5'd7,  7,
                32'h12345678};
      tv[1] = '{1'b1, 5'd7,  32'hAABBCCDD, 4'h5, 1'b1, 5'd7,  7,
                32'h12BB56DD};
      tv[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 1'b0, 5'd7,  0,
                32'h00000000};
      tv[3] = '{1'b1, 5'd9,  32'h11111111, 4'h0, 1'b0, 5'd7,  9,
                32'h00000000};
      tv[4] = '{1'b0, 5'd3,  32'h33333333, 4'hF, 1'b0, 5'd7,  3,
                32'h00000000};
      tv[5] = '{1'b1, 5'd31, 32'h00000001, 4'hF, 1'b1, 5'd31, 31,
                32'h00000001};
      tv[6] = '{1'b1, 5'd31, 32'h00000002, 4'hF, 1'b1, 5'd31, 31,
                32'h00000002};
      tv[7] = '{1'b1, 5'd31, 32'h0000AB00, 4'h2, 1'b1, 5'd31, 31,
                32'h0000AB02};
      tv[8] = '{1'b0, 5'd31, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd31, 31,
                32'h0000AB02};
      tv[9] = '{1'b1, 5'd1,  32'hCAFEF00D, 4'h8, 1'b1, 5'd1,  1,
                32'hCA000000};
      for (int i = 0; i < 32; i++) m[i] = '0;

      #12;
      chk("reset_ack", 32'(ack1), 32'd0);
      chk("reset_addr", 32'(addr1), 32'd0);
      chk_all("reset_regs");
      reset_n = 1'b1;
      @(negedge clk);

      drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
      chk("pre_rst_r5", rd(5), 32'hDEADBEEF);
      chk("pre_rst_ack", 32'(ack1), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_r5", rd(5), 32'h0);
      chk("mid_rst_ack", 32'(ack1), 32'd0);
      chk("mid_rst_addr", 32'(addr1), 32'd0);
      m[5] = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         drive(tv[i].we, tv[i].a, tv[i].d, tv[i].s);
         chk($sformatf("v%0d_ack", i), 32'(ack1), 32'(tv[i].ack));
         chk($sformatf("v%0d_addr", i), 32'(addr1), 32'(tv[i].eaddr));
         chk($sformatf("v%0d_reg", i), rd(5'(tv[i].idx)), tv[i].ev);
         chk_all($sformatf("v%0d_others", i));
         if (i == 2) begin
            chk("z0_r0_write", q0[0], 32'hFFFFFFFF);
            chk("z0_r0_ack", 32'(ack0), 32'd1);
            chk("z0_r0_addr", 32'(addr0), 32'd0);
         end
      end

      // Back-to-back ack: sampled before and after the second edge.
      we = 1'b1; waddr = 5'd20; wdata = 32'h1; wstrb = 4'hF;
      @(posedge clk); #1;
      chk("b2b_ack1", 32'(ack1), 32'd1);
      waddr = 5'd20; wdata = 32'h2;
      @(posedge clk); #1;
      chk("b2b_ack2", 32'(ack1), 32'd1);
      we = 1'b0;
      @(posedge clk); #1;
      chk("b2b_ack_drop", 32'(ack1), 32'd0);
      chk("b2b_r20", rd(5'd20), 32'h2);
      m[20] = 32'h2;

      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 4'hF);
         chk($sformatf("sw%0d_ack", i), 32'(ack1), (i != 0) ? 1 : 0);
      end
      for (int i = 0; i < 32; i++)
         chk($sformatf("sw%0d_rd", i), rd(5'(i)),
             (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
      chk("sw_z0_r0", q0[0], 32'h0);
      chk("sw_z0_r31", q0[31], 32'h1F1F1F1F);

      for (int i = 0; i < 32; i++) snap[i] = q1[i];
      for (int c = 0; c < 100; c++) begin
         drive(1'b0, 5'($urandom_range(0, 31)), $urandom,
               4'($urandom_range(0, 15)));
         if (ack1 !== 1'b0) chk("idle_ack", 32'(ack1), 32'd0);
      end
      chk_all("idle_regs");
      chk("idle_r17", rd(5'd17), 32'h11111111);

      we = 1'bx; waddr = 5'd4; wdata = m[4]; wstrb = 4'hF;
      @(posedge clk); #1;
      we = 1'b0;
      chk_all("x_we_regs");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
